vr_slice_serializer: RTL and testbench

//   Downstream consumer of the fqzplwax-class producer. It takes one packed
//   vr element per handshake (2x2x5x1 = 20 bits at the defaults) and emits it as
//   NUM_SLICES narrow slices, LSB slice first.

---
 rtl/vr_slice_serializer.sv | 143 ++++++++++++++
 tb/tb_vr_slice_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vr_slice_serializer.sv
// Word-to-slice serializer: a two-entry input FIFO feeds a shift register that
// emits each packed word as NUM_SLICES narrow slices, LSB slice first.
module vr_slice_serializer #(
   parameter int SLICE_W    = 5,
   parameter int NUM_SLICES = 4,
   parameter int ODD_PARITY = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [SLICE_W*NUM_SLICES-1:0]   in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [SLICE_W-1:0]              out_data,
   output logic [$clog2(NUM_SLICES)-1:0]   out_idx,
   output logic                            out_first,
   output logic                            out_last,
   output logic                            out_parity,
   output logic [7:0]                      word_cnt,
   output logic                            busy
);

   localparam int W     = SLICE_W * NUM_SLICES;
   localparam int IDX_W = $clog2(NUM_SLICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);
   localparam logic PAR_FLIP = (ODD_PARITY != 0);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t            state;
   state_t            stateNext;
   logic [W-1:0]      fifoMem [2];
   logic              wrPtr;
   logic              rdPtr;
   logic [1:0]        count;
   logic [1:0]        countNext;
   logic [W-1:0]      sr;
   logic [IDX_W-1:0]  idx;
   logic              push;
   logic              pop;
   logic              advance;
   logic              lastSlice;
   logic              wordDone;

   // Next-state logic: a pop loads the shift register, either from IDLE or
   // back-to-back when the final slice of the current word is accepted.
   always_comb begin
      stateNext = state;
      pop       = 1'b0;
      advance   = 1'b0;
      wordDone  = 1'b0;
      lastSlice = (idx == LAST_IDX);
      push      = in_valid && in_ready;
      case (state)
         IDLE: begin
            if (count != 2'd0) begin
               pop       = 1'b1;
               stateNext = SHIFT;
            end
         end
         SHIFT: begin
            if (out_ready) begin
               if (!lastSlice) begin
                  advance = 1'b1;
               end else begin
                  wordDone = 1'b1;
                  if (count != 2'd0) begin
                     pop = 1'b1;
                  end else begin
                     stateNext = IDLE;
                  end
               end
            end
         end
         default: stateNext = IDLE;
      endcase
      countNext = count + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // in_ready is registered from the post-update occupancy, so it stays low
   // for the whole cycle in which the FIFO is full even if a pop happens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifoMem[0] <= '0;
         fifoMem[1] <= '0;
         wrPtr      <= 1'b0;
         rdPtr      <= 1'b0;
         count      <= 2'd0;
         in_ready   <= 1'b0;
      end else begin
         if (push) begin
            fifoMem[wrPtr] <= in_data;
            wrPtr          <= ~wrPtr;
         end
         if (pop) begin
            rdPtr <= ~rdPtr;
         end
         count    <= countNext;
         in_ready <= (countNext != 2'd2);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr       <= '0;
         idx      <= '0;
         word_cnt <= 8'd0;
      end else begin
         if (pop) begin
            sr  <= fifoMem[rdPtr];
            idx <= '0;
         end else if (advance) begin
            sr  <= sr >> SLICE_W;
            idx <= idx + 1'b1;
         end
         if (wordDone) begin
            word_cnt <= word_cnt + 8'd1;
         end
      end
   end

   // Markers and parity are gated by out_valid so every output reads 0 in reset.
   assign out_valid  = (state == SHIFT);
   assign out_data   = sr[SLICE_W-1:0];
   assign out_idx    = idx;
   assign out_first  = out_valid & (idx == '0);
   assign out_last   = out_valid & lastSlice;
   assign out_parity = out_valid & ((^out_data) ^ PAR_FLIP);
   assign busy       = (count != 2'd0) || (state != IDLE);

endmodule

// File: tb/tb_vr_slice_serializer.sv
// Randomized bench for vr_slice_serializer: a word-queue reference model predicts
// every slice, handshake, counter and busy flag; an odd-parity copy runs alongside.
module tb_vr_slice_serializer;

   localparam int SW = 5;
   localparam int NS = 4;
   localparam int W  = SW * NS;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_data;
   logic [1:0]    out_idx;
   logic          out_first;
   logic          out_last;
   logic          out_parity;
   logic [7:0]    word_cnt;
   logic          busy;

   logic          oddInReady;
   logic          oddOutValid;
   logic [SW-1:0] oddOutData;
   logic [1:0]    oddOutIdx;
   logic          oddOutFirst;
   logic          oddOutLast;
   logic          oddOutParity;
   logic [7:0]    oddWordCnt;
   logic          oddBusy;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  wordQ [$];
   int            accQ [$];
   int            headPos;
   int            expCnt;
   int            edgeNum;
   bit            prevStall;
   logic [SW-1:0] prevData;
   logic [1:0]    prevIdx;

   vr_slice_serializer #(.SLICE_W(SW), .NUM_SLICES(NS), .ODD_PARITY(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
      .out_first(out_first), .out_last(out_last), .out_parity(out_parity),
      .word_cnt(word_cnt), .busy(busy)
   );

   vr_slice_serializer #(.SLICE_W(SW), .NUM_SLICES(NS), .ODD_PARITY(1)) dutOdd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(oddInReady), .in_data(in_data),
      .out_valid(oddOutValid), .out_ready(out_ready), .out_data(oddOutData), .out_idx(oddOutIdx),
      .out_first(oddOutFirst), .out_last(oddOutLast), .out_parity(oddOutParity),
      .word_cnt(oddWordCnt), .busy(oddBusy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, compare against the model,
   // then advance the model by the handshakes that the rising edge commits.
   task automatic applyStimulus(input logic iv, input logic [W-1:0] id, input logic ordy);
      logic         expValid;
      logic         expReady;
      logic         inHs;
      logic         outHs;
      int           pending;
      int           fifoCnt;
      logic [W-1:0] sh;
      logic [SW-1:0] sl;
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      pending   = wordQ.size();
      expValid  = 1'b0;
      if (pending > 0) expValid = (edgeNum >= accQ[0] + 1);
      fifoCnt   = pending - (expValid ? 1 : 0);
      expReady  = (fifoCnt < 2);
      checkOutput("out_valid", out_valid, expValid);
      checkOutput("in_ready", in_ready, expReady);
      checkOutput("busy", busy, pending > 0);
      checkOutput("word_cnt", word_cnt, expCnt);
      if (expValid) begin
         sh = wordQ[0] >> (headPos * SW);
         sl = sh[SW-1:0];
         checkOutput("out_data", out_data, sl);
         checkOutput("out_idx", out_idx, headPos);
         checkOutput("out_first", out_first, headPos == 0);
         checkOutput("out_last", out_last, headPos == NS - 1);
         checkOutput("parity_even", out_parity, ^sl);
         checkOutput("parity_odd", oddOutParity, ~^sl);
      end
      if (prevStall) begin
         checkOutput("hold_data", out_data, prevData);
         checkOutput("hold_idx", out_idx, prevIdx);
      end
      prevStall = out_valid && !ordy;
      prevData  = out_data;
      prevIdx   = out_idx;
      inHs  = iv && expReady;
      outHs = expValid && ordy;
      @(posedge clk);
      edgeNum++;
      if (outHs) begin
         headPos++;
         if (headPos == NS) begin
            void'(wordQ.pop_front());
            void'(accQ.pop_front());
            headPos = 0;
            expCnt  = (expCnt + 1) % 256;
         end
      end
      if (inHs) begin
         wordQ.push_back(id);
         accQ.push_back(edgeNum);
      end
   endtask

   task automatic pulseReset();
      #3;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_idx", out_idx, 0);
      checkOutput("rst_first_last", {out_first, out_last}, 0);
      checkOutput("rst_parity", {out_parity, oddOutParity}, 0);
      checkOutput("rst_word_cnt", word_cnt, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      wordQ.delete();
      accQ.delete();
      headPos   = 0;
      expCnt    = 0;
      edgeNum   = 0;
      prevStall = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("release_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("first_edge_in_ready", in_ready, 1);
   endtask

   initial begin
      int guard;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      pulseReset();

      // Single known word streamed with the consumer always ready
      applyStimulus(1'b1, 20'hABCDE, 1'b1);
      repeat (6) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("single_word_cnt", word_cnt, 1);

      // Three back-to-back words fill the FIFO and stream without bubbles
      repeat (3) applyStimulus(1'b1, W'($urandom), 1'b1);
      repeat (16) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("three_word_cnt", word_cnt, 4);

      // Consumer stall at slice 2
      applyStimulus(1'b1, W'($urandom), 1'b1);
      guard = 0;
      while (headPos != 2 && guard < 20) begin
         applyStimulus(1'b0, '0, 1'b1);
         guard++;
      end
      checkOutput("stall_reach_idx2", guard < 20, 1);
      repeat (5) applyStimulus(1'b0, '0, 1'b0);
      repeat (6) applyStimulus(1'b0, '0, 1'b1);

      // Reset while slice 1 is on the output and another word is buffered
      applyStimulus(1'b1, W'($urandom), 1'b1);
      applyStimulus(1'b1, W'($urandom), 1'b1);
      guard = 0;
      while (!(headPos == 1 && wordQ.size() == 2) && guard < 20) begin
         applyStimulus(1'b0, '0, 1'b1);
         guard++;
      end
      checkOutput("midword_reach", guard < 20, 1);
      pulseReset();
      applyStimulus(1'b1, W'($urandom), 1'b1);
      repeat (6) applyStimulus(1'b0, '0, 1'b1);

      // Random traffic with random back-pressure, including all-zero words
      repeat (600) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
                       ($urandom_range(0, 3) != 0));
      end

      // Saturated stream, long enough for word_cnt to wrap past 255
      repeat (1100) applyStimulus(1'b1, W'($urandom), 1'b1);
      repeat (16) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("drain_busy", busy, 0);
      checkOutput("drain_model_empty", wordQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
